am_ramloader: RTL and testbench

- Sequential writer for the bipolar PROM/RAM models in the AM29xx collection; the write-side counterpart to the 1024×4 ROM read path.
- Accepts a stream of WIDTH-bit words over a valid/ready handshake.
- Generates address, data, cs_ and a timed active-low we_ pulse toward an asynchronous writable control store, starting at a base address for a given length.
- Used by testbenches and microprogram bring-up to fill a writable control store before the sequencer runs.

---
 rtl/am_ramloader_pkg.sv | 21 ++
 rtl/am_ramloader_if.sv | 25 ++
 rtl/am_ramloader_wepulse.sv | 32 +++
 rtl/am_ramloader.sv | 194 +++++++++++++++++++
 tb/tb_am_ramloader.sv | 287 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/am_ramloader_pkg.sv
// Shared constants for the AM29xx RAM loader: state encoding and default geometry
// (the same WIDTH/HEIGHT defaults as the _genrom family).
package am_ramloader_pkg;

   localparam int DEF_WIDTH  = 4;
   localparam int DEF_HEIGHT = 10;

   localparam logic [2:0] IDLE  = 3'd0;
   localparam logic [2:0] FETCH = 3'd1;
   localparam logic [2:0] SETUP = 3'd2;
   localparam logic [2:0] PULSE = 3'd3;
   localparam logic [2:0] HOLD  = 3'd4;
   localparam logic [2:0] VREAD = 3'd5;
   localparam logic [2:0] NEXT  = 3'd6;

   // Chip select is asserted for the whole access window around the we_ pulse.
   function automatic logic state_selects(input logic [2:0] s);
      return (s == SETUP) || (s == PULSE) || (s == HOLD) || (s == VREAD);
   endfunction

endpackage

// File: rtl/am_ramloader_if.sv
// Word stream and asynchronous memory bus of the RAM loader.
// The master modport is the loader side; the slave side feeds data and models the memory.
interface am_ramloader_if #(
   parameter int WIDTH  = 4,
   parameter int HEIGHT = 10
);
   logic [WIDTH-1:0]  din;
   logic              din_valid;
   logic              din_ready;
   logic [HEIGHT-1:0] a;
   logic [WIDTH-1:0]  d;
   logic [WIDTH-1:0]  q;
   logic              cs_;
   logic              we_;

   modport master (
      input  din, din_valid, q,
      output din_ready, a, d, cs_, we_
   );

   modport slave (
      output din, din_valid, q,
      input  din_ready, a, d, cs_, we_
   );
endinterface

// File: rtl/am_ramloader_wepulse.sv
// Loadable down-counter timing the we_ pulse and the verify read window.
// tc is high when the count has reached zero.
module am_ramloader_wepulse #(
   parameter int CW = 1
) (
   input  logic          clk,
   input  logic          rst_,
   input  logic          load,
   input  logic [CW-1:0] load_val,
   output logic          tc
);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load)
         cnt_d = load_val;
      else if (cnt_q != '0)
         cnt_d = cnt_q - CW'(1);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

   assign tc = (cnt_q == '0);

endmodule

// File: rtl/am_ramloader.sv
// Sequential writer filling an asynchronous writable control store from a word stream.
// Define RAMLOADER_VERIFY_EN to add a read-back compare after each write (err/err_addr).
//
// state | meaning
// IDLE  | waiting for start
// FETCH | din_ready high, waiting for a word
// SETUP | cs_ low, address/data setup before we_
// PULSE | cs_ and we_ low for WE_CYC cycles
// HOLD  | we_ high again, address/data hold
// VREAD | cs_ low, read back q for RD_CYC cycles (verify builds only)
// NEXT  | deselect, advance address, count word
module am_ramloader
   import am_ramloader_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int HEIGHT = DEF_HEIGHT,
   parameter int WE_CYC = 2,
   parameter int RD_CYC = 1
) (
   input  logic              clk,
   input  logic              rst_,
   input  logic              start,
   input  logic [HEIGHT-1:0] base,
   input  logic [HEIGHT:0]   len,
   am_ramloader_if.master    bus,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic [HEIGHT-1:0] err_addr
);

   localparam int CNT_MAX = (WE_CYC > RD_CYC) ? WE_CYC : RD_CYC;
   localparam int CW      = (CNT_MAX < 2) ? 1 : $clog2(CNT_MAX);
   localparam logic [CW-1:0]   WE_LD   = CW'(WE_CYC - 1);
   localparam logic [HEIGHT:0] REM_ONE = (HEIGHT+1)'(1);
`ifdef RAMLOADER_VERIFY_EN
   localparam logic [CW-1:0]   RD_LD   = CW'(RD_CYC - 1);
`endif

   logic [2:0]        state_q, state_d;
   logic [HEIGHT-1:0] addr_q, addr_d;
   logic [WIDTH-1:0]  data_q, data_d;
   logic [HEIGHT:0]   rem_q, rem_d;
   logic              done_q, done_d;
   logic              busy_q, busy_d;
   logic              cs_n_q, cs_n_d;
   logic              we_n_q, we_n_d;
   logic              cnt_load;
   logic [CW-1:0]     cnt_val;
   logic              cnt_tc;

   am_ramloader_wepulse #(.CW(CW)) u_wepulse (
      .clk      (clk),
      .rst_     (rst_),
      .load     (cnt_load),
      .load_val (cnt_val),
      .tc       (cnt_tc)
   );

   always_comb begin
      state_d  = state_q;
      addr_d   = addr_q;
      data_d   = data_q;
      rem_d    = rem_q;
      done_d   = 1'b0;
      cnt_load = 1'b0;
      cnt_val  = WE_LD;
      case (state_q)
         IDLE: begin
            if (start) begin
               if (len != '0) begin
                  addr_d  = base;
                  rem_d   = len;
                  state_d = FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (bus.din_valid) begin
               data_d  = bus.din;
               state_d = SETUP;
            end
         end
         SETUP: begin
            cnt_load = 1'b1;
            cnt_val  = WE_LD;
            state_d  = PULSE;
         end
         PULSE: begin
            if (cnt_tc)
               state_d = HOLD;
         end
         HOLD: begin
`ifdef RAMLOADER_VERIFY_EN
            cnt_load = 1'b1;
            cnt_val  = RD_LD;
            state_d  = VREAD;
`else
            state_d  = NEXT;
`endif
         end
`ifdef RAMLOADER_VERIFY_EN
         VREAD: begin
            if (cnt_tc)
               state_d = NEXT;
         end
`endif
         NEXT: begin
            addr_d = addr_q + HEIGHT'(1);
            rem_d  = rem_q - REM_ONE;
            if (rem_q == REM_ONE) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else begin
               state_d = FETCH;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Strobes are registered from the next state so the async memory sees glitch-free edges.
   always_comb begin
      busy_d = (state_d != IDLE);
      cs_n_d = !state_selects(state_d);
      we_n_d = (state_d != PULSE);
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state_q <= IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         rem_q   <= '0;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
         cs_n_q  <= 1'b1;
         we_n_q  <= 1'b1;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         rem_q   <= rem_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
         cs_n_q  <= cs_n_d;
         we_n_q  <= we_n_d;
      end
   end

`ifdef RAMLOADER_VERIFY_EN
   logic              err_q, err_d;
   logic [HEIGHT-1:0] err_addr_q, err_addr_d;

   // Only the first mismatch since start is recorded.
   always_comb begin
      err_d      = err_q;
      err_addr_d = err_addr_q;
      if (state_q == IDLE && start) begin
         err_d = 1'b0;
      end else if (state_q == VREAD && cnt_tc && bus.q != data_q && !err_q) begin
         err_d      = 1'b1;
         err_addr_d = addr_q;
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         err_q      <= 1'b0;
         err_addr_q <= '0;
      end else begin
         err_q      <= err_d;
         err_addr_q <= err_addr_d;
      end
   end

   assign err      = err_q;
   assign err_addr = err_addr_q;
`else
   assign err      = 1'b0;
   assign err_addr = '0;
`endif

   assign bus.din_ready = (state_q == FETCH);
   assign bus.a         = addr_q;
   assign bus.d         = data_q;
   assign bus.cs_       = cs_n_q;
   assign bus.we_       = we_n_q;
   assign busy          = busy_q;
   assign done          = done_q;

endmodule

// File: tb/tb_am_ramloader.sv
// Scoreboard bench for am_ramloader: expected writes are queued at stimulus time and
// popped by a bus monitor on every completed we_ pulse.
module tb_am_ramloader;

   localparam int W = 4;
   localparam int H = 10;
   localparam int DEPTH = 1024;
`ifdef RAMLOADER_VERIFY_EN
   localparam int WCOST = 7;
`else
   localparam int WCOST = 6;
`endif

   typedef struct {
      int a;
      int d;
   } wr_t;

   logic         clk = 1'b0;
   logic         rst_ = 1'b0;
   logic         start = 1'b0;
   logic [H-1:0] base = '0;
   logic [H:0]   len = '0;
   logic         busy, done, err;
   logic [H-1:0] err_addr;

   logic [W-1:0] mem [DEPTH];
   wr_t          exp_q[$];
   logic [W-1:0] wq[$];
   int           nvec = 0;
   int           nbad = 0;
   int           cyc = 0;
   int           done_cnt = 0;
   int           done_cyc = 0;
   logic         prev_we = 1'b1;
   logic [H-1:0] pa = '0;
   logic [W-1:0] pd = '0;

   am_ramloader_if #(.WIDTH(W), .HEIGHT(H)) bus ();

   am_ramloader #(.WIDTH(W), .HEIGHT(H), .WE_CYC(2), .RD_CYC(1)) dut (
      .clk      (clk),
      .rst_     (rst_),
      .start    (start),
      .base     (base),
      .len      (len),
      .bus      (bus.master),
      .busy     (busy),
      .done     (done),
      .err      (err),
      .err_addr (err_addr)
   );

   assign bus.q = mem[bus.a];

   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   task automatic chk(input string nm, input longint got, input longint exp);
      nvec++;
      if (got !== exp) begin
         nbad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
      end
   endtask

   // Bus monitor: invariants while we_ is low, scoreboard pop on each we_ rising edge.
   always @(negedge clk) begin
      wr_t e;
      if (!rst_) begin
         prev_we = 1'b1;
      end else begin
         if (!bus.we_) begin
            chk("we_implies_cs", bus.cs_, 0);
            if (!prev_we) begin
               chk("a_stable_we", bus.a, pa);
               chk("d_stable_we", bus.d, pd);
            end
            pa = bus.a;
            pd = bus.d;
         end else if (!prev_we) begin
            nvec++;
            if (exp_q.size() == 0) begin
               nbad++;
               $display("FAIL spurious_write: got write a=0x%0h d=0x%0h expected none", bus.a, bus.d);
            end else begin
               e = exp_q.pop_front();
               chk("wr_addr", bus.a, e.a);
               chk("wr_data", bus.d, e.d);
            end
`ifdef RAMLOADER_VERIFY_EN
            mem[bus.a] = (bus.a == 10'h005) ? (bus.d & 4'b1011) : bus.d;
`else
            mem[bus.a] = bus.d;
`endif
         end
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         prev_we = bus.we_;
      end
   end

   task automatic do_load(input int b, input int gap, input bit rnd_gap, input bit dbl);
      int n = wq.size();
      int dc0, st, t, g;
      logic [H-1:0] bb;
      bit nogap = (gap == 0) && !dbl;
      bb = b[H-1:0];
      for (int i = 0; i < n; i++)
         exp_q.push_back('{a: (b + i) % DEPTH, d: int'(wq[i])});
      dc0 = done_cnt;
      @(negedge clk);
      start = 1'b1;
      base  = bb;
      len   = n[H:0];
      @(posedge clk);
      #1;
      st = cyc;
      start = 1'b0;
      chk("busy_after_start", busy, (n != 0));
      if (n == 0) begin
         @(negedge clk);
         chk("len0_done", done, 1);
         chk("len0_busy", busy, 0);
         repeat (3) begin
            @(negedge clk);
            chk("len0_cs", bus.cs_, 1);
         end
         chk("len0_done_once", done_cnt - dc0, 1);
         return;
      end
      for (int i = 0; i < n; i++) begin
         g = rnd_gap ? $urandom_range(0, gap) : gap;
         if (g > 0) begin
            bus.din_valid = 1'b0;
            repeat (g) begin
               @(negedge clk);
               if (bus.din_ready) begin
                  chk("gap_we", bus.we_, 1);
                  chk("gap_cs", bus.cs_, 1);
               end
            end
         end
         bus.din = wq[i];
         bus.din_valid = 1'b1;
         t = 0;
         while (!bus.din_ready && t < 100) begin
            @(negedge clk);
            t++;
         end
         chk("din_ready_timeout", (t < 100), 1);
         @(posedge clk);
         #1;
         bus.din_valid = 1'b0;
         if (dbl && i == 0) begin
            @(negedge clk);
            start = 1'b1;
            base  = ~bb;
            len   = 11'd7;
            @(negedge clk);
            start = 1'b0;
         end
      end
      t = 0;
      while (done_cnt == dc0 && t < 200) begin
         @(negedge clk);
         t++;
      end
      chk("done_seen", done_cnt - dc0, 1);
      if (nogap)
         chk("load_cycles", done_cyc - st, n * WCOST);
      repeat (3) @(negedge clk);
      chk("done_once", done_cnt - dc0, 1);
      chk("busy_end", busy, 0);
      chk("writes_left", exp_q.size(), 0);
      chk("a_end", bus.a, (b + n) % DEPTH);
   endtask

   task automatic mem_chk(input int b);
      for (int i = 0; i < wq.size(); i++)
         chk("mem_contents", mem[(b + i) % DEPTH], wq[i]);
   endtask

   initial begin
      int t;
      for (int i = 0; i < DEPTH; i++) mem[i] = '0;
      bus.din = '0;
      bus.din_valid = 1'b0;

      #12;
      chk("rst_a", bus.a, 0);
      chk("rst_d", bus.d, 0);
      chk("rst_cs", bus.cs_, 1);
      chk("rst_we", bus.we_, 1);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_din_ready", bus.din_ready, 0);
      chk("rst_err", err, 0);
      chk("rst_err_addr", err_addr, 0);
      @(negedge clk);
      #2 rst_ = 1'b1;

      wq = '{4'hA, 4'h5, 4'hF};
      do_load(32'h010, 0, 1'b0, 1'b0);
      mem_chk(32'h010);

      wq = '{4'h1, 4'h2, 4'h3, 4'h4};
      do_load(32'h3FE, 0, 1'b0, 1'b0);
      mem_chk(32'h3FE);

      wq = '{4'h7, 4'hC, 4'h9};
      do_load(32'h120, 5, 1'b0, 1'b0);
      mem_chk(32'h120);

      wq.delete();
      do_load(32'h200, 0, 1'b0, 1'b0);

      wq = '{4'h6, 4'hB, 4'h2, 4'hE};
      do_load(32'h080, 0, 1'b0, 1'b1);
      mem_chk(32'h080);

      repeat (6) begin
         int n;
         n = $urandom_range(1, 8);
         wq.delete();
         for (int i = 0; i < n; i++) wq.push_back(4'($urandom_range(0, 15)));
         do_load($urandom_range(0, DEPTH - 1), 3, 1'b1, 1'($urandom_range(0, 1)));
      end

`ifdef RAMLOADER_VERIFY_EN
      wq = '{4'h4};
      do_load(32'h005, 0, 1'b0, 1'b0);
      chk("verify_err", err, 1);
      chk("verify_err_addr", err_addr, 10'h005);
      wq = '{4'h3};
      do_load(32'h005, 0, 1'b0, 1'b0);
      chk("verify_err_clean", err, 0);
`else
      chk("err_tied", err, 0);
      chk("err_addr_tied", err_addr, 0);
`endif

      // Asynchronous reset in the middle of a we_ pulse: nothing gets queued, so a
      // completed write afterwards would show up as spurious.
      @(negedge clk);
      start = 1'b1;
      base  = 10'h100;
      len   = 11'd3;
      @(posedge clk);
      #1;
      start = 1'b0;
      bus.din = 4'h9;
      bus.din_valid = 1'b1;
      t = 0;
      while (bus.we_ && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("saw_pulse", bus.we_, 0);
      #2 rst_ = 1'b0;
      #1;
      chk("arst_we", bus.we_, 1);
      chk("arst_cs", bus.cs_, 1);
      chk("arst_busy", busy, 0);
      chk("arst_din_ready", bus.din_ready, 0);
      chk("arst_a", bus.a, 0);
      bus.din_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      #2 rst_ = 1'b1;
      repeat (8) @(negedge clk);
      chk("arst_idle_busy", busy, 0);
      chk("arst_idle_cs", bus.cs_, 1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: got no completion expected finish within time limit");
      $fatal(1, "watchdog expired");
   end

endmodule
